hilo_md_ctrl: RTL and testbench
===============================

Name: hilo_md_ctrl

Overview:
Sequencer for the HI/LO resource of the CPU: it accepts MULT/MULTU/DIV/DIVU from the EX stage and runs them over multiple cycles, then owns and updates the HI/LO registers. It also services MTHI/MTLO writes and tells the pipeline hazard logic when to stall. While it is busy, it stalls any instruction that touches HI/LO. Its HI/LO outputs feed the EX-stage MFHI/MFLO mux and travel down the pipeline to the write-back register stage.

Parameters:
MUL_LAT, 4, cycles busy for MULT/MULTU (legal 1..16)
DIV_LAT, 33, cycles busy for DIV/DIVU (32 restoring iterations + 1 sign fix-up); fixed, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  EX stage issues a mul/div this cycle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid with start
src_a  input  32  rs operand (multiplicand / dividend)
src_b  input  32  rt operand (multiplier / divisor)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  32  MTHI/MTLO data
mf_req  input  1  EX-stage instruction reads HI or LO (MFHI/MFLO)
busy  output  1  operation in progress
stall  output  1  to hazard unit: hold IF/ID/EX this cycle
done  output  1  one-cycle pulse when HI/LO take a mul/div result
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset: asynchronous, active-high; applies at any time, including mid-operation. State=IDLE, counter=0; busy, stall and done = 0; HI = LO = 0. Any in-flight result is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on start with op[1]=0.
  - IDLE -> DIV on start with op[1]=1.
  - MUL -> IDLE after MUL_LAT cycles.
  - DIV -> FIX after 32 iterations.
  - FIX -> IDLE after 1 cycle.
- Acceptance: start is accepted only in IDLE.
  - At the accepting edge: operands and op are latched and the counter is loaded.
  - busy = 1 from the next cycle for exactly MUL_LAT or DIV_LAT cycles.
- Completion: at the edge ending the last busy cycle:
  - HI/LO are written and busy falls.
  - done = 1 for the following single cycle.
  - New HI/LO values are visible in that same cycle.
  - A new start is accepted in that done cycle.
- stall = busy & (start | mthi | mtlo | mf_req). This is combinational, and the request is not accepted that cycle. Upstream holds the request until stall drops.
- mthi/mtlo in IDLE: the targeted register takes wdata at the edge. mthi and mtlo may both be high in the same cycle.
- If start and mthi/mtlo are high in the same IDLE cycle:
  - start wins and mthi/mtlo are ignored.
  - The upstream never issues this combination; the bench asserts on it.
- Multiply:
  - Signed or unsigned 32x32 -> 64 product.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Operands are converted to magnitudes; then a 32-step restoring divide runs, one bit per cycle.
  - FIX applies signs: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide boundary cases:
  - Divide by zero (either signedness): LO = 32'hFFFF_FFFF, HI = src_a. Normal DIV_LAT latency, no exception.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0 (wraps, no trap).
- mf_req in IDLE: no stall; HI/LO are already current.

Decomposition:
- Shared package hilo_md_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - the state enum
  - DIV_LAT = 33
- One sub-module, md_div_iter: the restoring-division datapath, with ports load, step, magnitudes in, and quotient/remainder out.
- Sign handling and the FSM live in hilo_md_ctrl.

Test Plan:
- Signed multiply: MULT src_a=32'hFFFF_FFFD (-3), src_b=5 -> busy for 4 cycles, then done pulse; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1.
- Unsigned multiply: MULTU src_a=src_b=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- Signed and unsigned divide:
  - DIV -7/2 -> busy for 33 cycles; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
  - DIVU 100/7 -> LO=14, HI=2.
- Divide by zero and overflow:
  - DIVU 0x1234/0 -> LO=32'hFFFF_FFFF, HI=32'h0000_1234.
  - DIV 0x8000_0000/-1 -> LO=32'h8000_0000, HI=0.
- Stall behaviour:
  - During a DIV, hold mf_req high -> stall=1 every busy cycle, stall=0 in the done cycle.
  - During a DIV, hold mthi with wdata=5 -> ignored while busy; HI=5 one edge after busy falls.
- Reset mid-operation: assert rst in DIV busy cycle 10 -> busy, stall and done = 0 immediately (before the next edge); HI = LO = 0. After release, MULT 2*3 yields LO=6, HI=0.

Source files
------------

// File: rtl/hilo_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM states, divide latency and small sign-handling helpers.
package hilo_md_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // 32 restoring iterations plus one sign fix-up cycle
    localparam int unsigned DIV_LAT = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic negate);
        return negate ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_md_if.sv
// EX-stage request / HI-LO status bundle between the pipeline and the sequencer.
interface hilo_md_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata, mf_req,
        input  busy, stall, done, HI, LO
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata, mf_req,
        output busy, stall, done, HI, LO
    );
endinterface

// File: rtl/md_div_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step on magnitudes.
module md_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;

    // Trial subtraction; bit 32 of the difference flags a negative result.
    always_comb begin
        rem_sh_s = {rem_q, quot_q[31]};
        diff_s   = rem_sh_s - {1'b0, dvs_q};
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        if (load_i) begin
            quot_d = dividend_i;
            rem_d  = 32'd0;
            dvs_d  = divisor_i;
        end else if (step_i) begin
            if (!diff_s[32]) begin
                rem_d  = diff_s[31:0];
                quot_d = {quot_q[30:0], 1'b1};
            end else begin
                rem_d  = rem_sh_s[31:0];
                quot_d = {quot_q[30:0], 1'b0};
            end
        end else begin
            quot_d = quot_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= 32'd0;
            rem_q  <= 32'd0;
            dvs_q  <= 32'd0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO sequencer: runs MULT/MULTU/DIV/DIVU over several cycles, owns HI/LO,
// services MTHI/MTLO and stalls the pipeline while an operation is in flight.
module hilo_md_ctrl
    import hilo_md_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic     clk,
    input  logic     rst,
    hilo_md_if.slave md
);
    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT - 2);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        div_load_s;
    logic        div_step_s;
    logic        in_signed_s;
    logic        op_signed_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic signed [63:0] ext_a_s;
    logic signed [63:0] ext_b_s;
    logic signed [63:0] prod_s;

    assign in_signed_s = (md.op == OP_DIV);
    assign op_signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);

    // Same 64x64 product serves both signednesses via the extension bits.
    assign ext_a_s = {{32{op_signed_s & a_q[31]}}, a_q};
    assign ext_b_s = {{32{op_signed_s & b_q[31]}}, b_q};
    assign prod_s  = ext_a_s * ext_b_s;

    md_div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load_s),
        .step_i     (div_step_s),
        .dividend_i (mag32(md.src_a, in_signed_s)),
        .divisor_i  (mag32(md.src_b, in_signed_s)),
        .quot_o     (quot_s),
        .rem_o      (rem_s)
    );

    // Next-state, operand capture and HI/LO update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_load_s = 1'b0;
        div_step_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    op_d       = md.op;
                    a_d        = md.src_a;
                    b_d        = md.src_b;
                    div_load_s = md.op[1];
                    cnt_d      = md.op[1] ? DIV_CNT : MUL_CNT;
                    state_d    = md.op[1] ? ST_DIV : ST_MUL;
                end else begin
                    hi_d = md.mthi ? md.wdata : hi_q;
                    lo_d = md.mtlo ? md.wdata : lo_q;
                end
            end
            ST_MUL: begin
                if (cnt_q == 5'd0) begin
                    hi_d    = prod_s[63:32];
                    lo_d    = prod_s[31:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_DIV: begin
                div_step_s = 1'b1;
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FIX: begin
                // Zero divisor bypasses the magnitudes: all-ones quotient, dividend as remainder.
                if (b_q == 32'd0) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = neg_if(quot_s, op_signed_s & (a_q[31] ^ b_q[31]));
                    hi_d = neg_if(rem_s, op_signed_s & a_q[31]);
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Sequencer state and architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign md.busy  = (state_q != ST_IDLE);
    assign md.stall = md.busy & (md.start | md.mthi | md.mtlo | md.mf_req);
    assign md.done  = done_q;
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_hilo_md_ctrl;
    import hilo_md_pkg::*;

    localparam int unsigned MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_md_if bus ();

    hilo_md_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus.slave)
    );

    always #5 clk = ~clk;

    // The upstream never combines start with mthi/mtlo.
    always @(negedge clk) begin
        assert (!(bus.start && (bus.mthi || bus.mtlo)))
        else begin
            errors++;
            $error("FAIL start_with_mt: start=%0b mthi=%0b mtlo=%0b", bus.start, bus.mthi, bus.mtlo);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result as {HI, LO}, straight from the arithmetic definition.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == OP_DIVU) return {32'(ua % ub), 32'(ua / ub)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called just after a falling edge; issues one op and checks latency, stall and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic hold_mf, input logic hold_mthi, input logic [31:0] wd,
                          input string tag);
        logic [63:0] e;
        logic [31:0] prev_hi, prev_lo;
        int nb, lat, bad;
        e       = model(o, a, b);
        lat     = o[1] ? int'(DIV_LAT) : int'(MUL_LAT);
        prev_hi = m_hi;
        prev_lo = m_lo;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mf_req = hold_mf;
        bus.mthi   = hold_mthi;
        bus.wdata  = wd;
        #1;
        chk({tag, "_done_low"}, {63'd0, bus.done}, 64'd0);
        nb  = 0;
        bad = 0;
        while (bus.busy === 1'b1 && nb < 100) begin
            nb++;
            if (bus.stall !== (hold_mf | hold_mthi)) bad++;
            if (bus.HI !== prev_hi || bus.LO !== prev_lo) bad++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_latency"}, 64'(nb), 64'(lat));
        chk({tag, "_busy_stall"}, 64'(bad), 64'd0);
        chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
        chk({tag, "_stall_done"}, {63'd0, bus.stall}, 64'd0);
        chk({tag, "_hilo"}, {bus.HI, bus.LO}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
        if (hold_mthi) begin
            @(negedge clk);
            #1;
            m_hi = wd;
            chk({tag, "_mthi_after"}, {bus.HI, bus.LO}, {m_hi, m_lo});
        end
        bus.mf_req = 1'b0;
        bus.mthi   = 1'b0;
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.wdata  = 32'd0;
        bus.mf_req = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", {bus.busy, bus.stall, bus.done}, 64'd0);
        chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // MTHI and MTLO together in IDLE, with an MFHI that must not stall.
        bus.mthi   = 1'b1;
        bus.mtlo   = 1'b1;
        bus.wdata  = 32'hA5A5_5A5A;
        bus.mf_req = 1'b1;
        #1;
        chk("mf_idle_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.mf_req = 1'b0;
        #1;
        m_hi = 32'hA5A5_5A5A;
        m_lo = 32'hA5A5_5A5A;
        chk("mt_both", {bus.HI, bus.LO}, {m_hi, m_lo});
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mtlo = 1'b0;
        #1;
        m_lo = 32'h0BAD_F00D;
        chk("mtlo_only", {bus.HI, bus.LO}, {m_hi, m_lo});

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,        1'b0, 1'b0, 32'd0, "mult_neg");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, "multu_max");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 1'b0, 32'd0, "div_neg");
        run_op(OP_DIVU,  32'd100,       32'd7,        1'b0, 1'b0, 32'd0, "divu_100_7");
        run_op(OP_DIVU,  32'h0000_1234, 32'd0,        1'b0, 1'b0, 32'd0, "divu_zero");
        run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0,        1'b0, 1'b0, 32'd0, "div_zero");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, "div_ovf");
        run_op(OP_DIV,   32'd1000,      32'hFFFF_FFFD, 1'b1, 1'b0, 32'd0, "div_mf_stall");
        run_op(OP_DIV,   32'hFFFF_FF9C, 32'd7,        1'b0, 1'b1, 32'd5, "div_mthi_hold");

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 7) == 0) r_b = 32'd0;
            if ($urandom_range(0, 3) == 0) r_b = r_b & 32'h0000_00FF;
            run_op(r_op, r_a, r_b, 1'b0, 1'b0, 32'd0, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a divide.
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        #1;
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'd12345;
        bus.src_b = 32'd17;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mf_req = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        chk("pre_rst_stall", {bus.busy, bus.stall}, 64'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", {bus.busy, bus.stall, bus.done}, 64'd0);
        chk("mid_rst_hilo", {bus.HI, bus.LO}, 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        bus.mf_req = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        run_op(OP_MULT, 32'd2, 32'd3, 1'b0, 1'b0, 32'd0, "post_rst_mult");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
